// File: rtl/instr_sequencer_if.sv
// Program-ROM read port and processor Din/run/Done handshake used by the sequencer.
// master = sequencer side, slave = ROM + processor side.
interface instr_sequencer_if #(
  parameter int ADDR_W = 4
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [8:0]        mem_rdata;
  logic [8:0]        proc_din;
  logic              proc_run;
  logic              proc_done;

  modport master (
    output mem_rd_en, mem_addr, proc_din, proc_run,
    input  mem_rdata, proc_done
  );

  modport slave (
    input  mem_rd_en, mem_addr, proc_din, proc_run,
    output mem_rdata, proc_done
  );
endinterface

// File: rtl/instr_sequencer.sv
// Program sequencer: fetches 9-bit words from a synchronous-read ROM, presents them on
// the processor Din bus with run pulses (two for mvi), and advances on Done.
module instr_sequencer #(
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] prog_len,
  instr_sequencer_if.master bus,
  output logic              busy,
  output logic              halted,
  output logic              error,
  output logic [ADDR_W-1:0] pc,
  output logic [7:0]        instr_cnt
);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_LOAD, S_RUN, S_IFETCH, S_ILOAD, S_IRUN, S_WAIT_DONE, S_HALT
  } state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [7:0]        cnt_reg;
  logic              error_reg;
  logic              rd_en_reg;
  logic              run_reg;
  logic              mvi_reg;
  logic [8:0]        din_reg;
  logic [TW-1:0]     wait_reg;

  logic [2:0]        opcode;
  logic [ADDR_W:0]   imm_addr;
  logic [ADDR_W-1:0] pc_next;

  assign opcode   = bus.mem_rdata[8:6];
  // Widened so the immediate address of the last word compares correctly against prog_len.
  assign imm_addr = {1'b0, pc_reg} + (ADDR_W+1)'(1);
  assign pc_next  = pc_reg + (mvi_reg ? ADDR_W'(2) : ADDR_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      pc_reg    <= '0;
      addr_reg  <= '0;
      cnt_reg   <= '0;
      error_reg <= 1'b0;
      rd_en_reg <= 1'b0;
      run_reg   <= 1'b0;
      mvi_reg   <= 1'b0;
      din_reg   <= '0;
      wait_reg  <= '0;
    end else begin
      rd_en_reg <= 1'b0;
      run_reg   <= 1'b0;
      case (state_reg)
        S_IDLE, S_HALT: begin
          if (start) begin
            pc_reg    <= '0;
            cnt_reg   <= '0;
            error_reg <= 1'b0;
            if (prog_len == '0) begin
              state_reg <= S_HALT;
            end else begin
              state_reg <= S_FETCH;
              rd_en_reg <= 1'b1;
              addr_reg  <= '0;
            end
          end
        end
        S_FETCH: state_reg <= S_LOAD;
        S_LOAD: begin
          mvi_reg <= (opcode == 3'b001);
          if (opcode == 3'b111) begin
            state_reg <= S_HALT;
          end else if (opcode[2] || (opcode == 3'b001 && imm_addr >= {1'b0, prog_len})) begin
            error_reg <= 1'b1;
            state_reg <= S_HALT;
          end else begin
            din_reg   <= bus.mem_rdata;
            state_reg <= S_RUN;
          end
        end
        // run is registered, so Din has been stable a full cycle when the pulse appears.
        S_RUN: begin
          run_reg <= 1'b1;
          if (mvi_reg) begin
            state_reg <= S_IFETCH;
            rd_en_reg <= 1'b1;
            addr_reg  <= pc_reg + ADDR_W'(1);
          end else begin
            state_reg <= S_WAIT_DONE;
            wait_reg  <= '0;
          end
        end
        S_IFETCH: state_reg <= S_ILOAD;
        S_ILOAD: begin
          din_reg   <= bus.mem_rdata;
          state_reg <= S_IRUN;
        end
        S_IRUN: begin
          run_reg   <= 1'b1;
          wait_reg  <= '0;
          state_reg <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (bus.proc_done) begin
            if (cnt_reg != 8'hFF) cnt_reg <= cnt_reg + 8'd1;
            pc_reg <= pc_next;
            if (stop || pc_next >= prog_len) begin
              state_reg <= S_HALT;
            end else begin
              state_reg <= S_FETCH;
              rd_en_reg <= 1'b1;
              addr_reg  <= pc_next;
            end
          end else if (wait_reg == TW'(TIMEOUT - 1)) begin
            error_reg <= 1'b1;
            state_reg <= S_HALT;
          end else begin
            wait_reg <= wait_reg + TW'(1);
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_rd_en = rd_en_reg;
  assign bus.mem_addr  = addr_reg;
  assign bus.proc_din  = din_reg;
  assign bus.proc_run  = run_reg;
  assign busy          = (state_reg != S_IDLE) && (state_reg != S_HALT);
  assign halted        = (state_reg == S_HALT);
  assign error         = error_reg;
  assign pc            = pc_reg;
  assign instr_cnt     = cnt_reg;
endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: ROM and processor models, run-word scoreboard and
// directed scenarios for mvi, stop, illegal opcode, timeout, reset abort and start handling.
module tb_instr_sequencer;
  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 15;

  logic              clk;
  logic              rst;
  logic              start;
  logic              stop;
  logic [ADDR_W-1:0] prog_len;
  logic              busy;
  logic              halted;
  logic              error;
  logic [ADDR_W-1:0] pc;
  logic [7:0]        instr_cnt;

  instr_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  instr_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .prog_len(prog_len),
    .bus(bus), .busy(busy), .halted(halted), .error(error), .pc(pc),
    .instr_cnt(instr_cnt)
  );

  int         vectors = 0;
  int         miscompares = 0;
  int         run_cnt = 0;
  int         rd_cnt = 0;
  logic       run_prev = 1'b0;
  logic [8:0] exp_q[$];
  logic [8:0] rom [16];
  logic [8:0] regs [8];
  int         done_lat = 2;
  bit         done_en = 1'b1;
  int         cd = 0;
  bit         pend = 1'b0;
  logic [2:0] pdst = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read program ROM
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rdata <= rom[bus.mem_addr];
  end

  // Processor model: executes mv/mvi/add/sub and answers with Done after done_lat cycles
  always @(posedge clk) begin
    bus.proc_done <= 1'b0;
    if (rst) begin
      cd   <= 0;
      pend <= 1'b0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      if (cd != 0) begin
        cd <= cd - 1;
        if (cd == 1) bus.proc_done <= 1'b1;
      end
      if (bus.proc_run) begin
        if (pend) begin
          regs[pdst] <= bus.proc_din;
          pend <= 1'b0;
          if (done_en) cd <= done_lat;
        end else begin
          case (bus.proc_din[8:6])
            3'b000: regs[bus.proc_din[5:3]] <= regs[bus.proc_din[2:0]];
            3'b001: begin pend <= 1'b1; pdst <= bus.proc_din[5:3]; end
            3'b010: regs[bus.proc_din[5:3]] <= regs[bus.proc_din[5:3]] + regs[bus.proc_din[2:0]];
            3'b011: regs[bus.proc_din[5:3]] <= regs[bus.proc_din[5:3]] - regs[bus.proc_din[2:0]];
            default: ;
          endcase
          if (bus.proc_din[8:6] != 3'b001 && done_en) cd <= done_lat;
        end
      end
    end
  end

  // Run monitor: every run pulse must be one cycle wide and carry the next expected word
  initial begin
    forever begin
      @(negedge clk);
      if (bus.mem_rd_en) rd_cnt++;
      if (bus.proc_run) begin
        run_cnt++;
        vectors++;
        if (run_prev) begin
          miscompares++;
          $display("FAIL run_width: proc_run high 2 cycles, required 1");
        end
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL run_word: unexpected run with din=%h, required no run", bus.proc_din);
        end else begin
          logic [8:0] exp_w;
          exp_w = exp_q.pop_front();
          if (bus.proc_din !== exp_w) begin
            miscompares++;
            $display("FAIL run_word: din=%h required %h", bus.proc_din, exp_w);
          end else begin
            $display("run word %h ok", bus.proc_din);
          end
        end
      end
      run_prev = bus.proc_run;
    end
  end

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    run_cnt = 0;
    rd_cnt = 0;
    done_en = 1'b1;
    done_lat = 2;
    for (int i = 0; i < 16; i++) rom[i] = 9'b111_000_000;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic push_words(input int first, input int n);
    for (int i = first; i < first + n; i++) exp_q.push_back(rom[i]);
  endtask

  task automatic wait_halt(input string name);
    int n = 0;
    while (!halted && n < 300) begin @(negedge clk); n++; end
    vectors++;
    if (!halted) begin
      miscompares++;
      $display("FAIL %s_halt_timeout: halted=%b after %0d cycles, required 1", name, halted, n);
    end
  endtask

  task automatic wait_runs(input int k, input string name);
    int seen = 0;
    int n = 0;
    while (seen < k && n < 200) begin
      @(negedge clk); n++;
      if (bus.proc_run) seen++;
    end
    vectors++;
    if (seen < k) begin
      miscompares++;
      $display("FAIL %s_run_wait: saw %0d runs, required %0d", name, seen, k);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; stop = 1'b0; prog_len = 4'd3;
    repeat (3) @(negedge clk);
    vectors += 4;
    if ({busy, halted, error} !== 3'b000) begin miscompares++; $display("FAIL reset_flags: %b required 000", {busy, halted, error}); end
    if ({pc, instr_cnt} !== 12'h000) begin miscompares++; $display("FAIL reset_pc_cnt: pc=%0d cnt=%0d required 0", pc, instr_cnt); end
    if (bus.proc_din !== 9'h000) begin miscompares++; $display("FAIL reset_din: %h required 000", bus.proc_din); end
    if ({bus.proc_run, bus.mem_rd_en, bus.mem_addr} !== 6'b0) begin miscompares++; $display("FAIL reset_bus: run=%b rd=%b addr=%0d required 0", bus.proc_run, bus.mem_rd_en, bus.mem_addr); end
    $display("reset check done");
    start = 1'b0;
  endtask

  task automatic test_mvi_program();
    do_reset();
    rom[0] = 9'b001_000_000; rom[1] = 9'd5;
    rom[2] = 9'b001_001_000; rom[3] = 9'd3;
    rom[4] = 9'b010_000_001; rom[5] = 9'b111_000_000;
    prog_len = 4'd5;
    push_words(0, 5);
    pulse_start();
    wait_halt("mvi");
    vectors += 5;
    if ({halted, error} !== 2'b10) begin miscompares++; $display("FAIL mvi_flags: halted/error=%b required 10", {halted, error}); end
    if (instr_cnt !== 8'd3) begin miscompares++; $display("FAIL mvi_cnt: %0d required 3", instr_cnt); end
    if (pc !== 4'd5) begin miscompares++; $display("FAIL mvi_pc: %0d required 5", pc); end
    if (regs[0] !== 9'd8) begin miscompares++; $display("FAIL mvi_r0: %0d required 8", regs[0]); end
    if (run_cnt != 5 || exp_q.size() != 0) begin miscompares++; $display("FAIL mvi_runs: %0d runs, %0d left, required 5 runs 0 left", run_cnt, exp_q.size()); end
    $display("mvi program: cnt=%0d pc=%0d r0=%0d runs=%0d", instr_cnt, pc, regs[0], run_cnt);
  endtask

  task automatic test_stop();
    do_reset();
    for (int i = 0; i < 4; i++) rom[i] = 9'b000_010_000;
    prog_len = 4'd4;
    done_lat = 3;
    push_words(0, 2);
    pulse_start();
    wait_runs(2, "stop");
    stop = 1'b1;
    wait_halt("stop");
    stop = 1'b0;
    vectors += 3;
    if (instr_cnt !== 8'd2) begin miscompares++; $display("FAIL stop_cnt: %0d required 2", instr_cnt); end
    if (pc !== 4'd2) begin miscompares++; $display("FAIL stop_pc: %0d required 2", pc); end
    if (run_cnt != 2 || error !== 1'b0) begin miscompares++; $display("FAIL stop_runs: runs=%0d error=%b required 2/0", run_cnt, error); end
    $display("stop: cnt=%0d pc=%0d", instr_cnt, pc);
  endtask

  task automatic test_illegal();
    do_reset();
    rom[0] = 9'b100_000_000;
    prog_len = 4'd4;
    pulse_start();
    wait_halt("illegal");
    repeat (2) @(negedge clk);
    vectors += 2;
    if ({halted, error} !== 2'b11) begin miscompares++; $display("FAIL illegal_flags: %b required 11", {halted, error}); end
    if (run_cnt != 0 || instr_cnt !== 8'd0) begin miscompares++; $display("FAIL illegal_runs: runs=%0d cnt=%0d required 0/0", run_cnt, instr_cnt); end
    $display("illegal opcode: error=%b", error);
  endtask

  task automatic test_halt_op();
    do_reset();
    rom[0] = 9'b000_001_010; rom[1] = 9'b111_000_000; rom[2] = 9'b000_001_010;
    prog_len = 4'd3;
    push_words(0, 1);
    pulse_start();
    wait_halt("haltop");
    vectors += 2;
    if ({halted, error, instr_cnt} !== {2'b10, 8'd1}) begin miscompares++; $display("FAIL haltop_state: h/e=%b cnt=%0d required 10/1", {halted, error}, instr_cnt); end
    if (pc !== 4'd1 || run_cnt != 1) begin miscompares++; $display("FAIL haltop_pc: pc=%0d runs=%0d required 1/1", pc, run_cnt); end
    $display("halt opcode: cnt=%0d pc=%0d", instr_cnt, pc);
  endtask

  task automatic test_mvi_oob();
    do_reset();
    rom[0] = 9'b000_001_010; rom[1] = 9'b001_000_000; rom[2] = 9'd9;
    prog_len = 4'd2;
    push_words(0, 1);
    pulse_start();
    wait_halt("oob");
    repeat (2) @(negedge clk);
    vectors += 2;
    if ({halted, error, instr_cnt} !== {2'b11, 8'd1}) begin miscompares++; $display("FAIL oob_state: h/e=%b cnt=%0d required 11/1", {halted, error}, instr_cnt); end
    if (pc !== 4'd1 || run_cnt != 1) begin miscompares++; $display("FAIL oob_pc: pc=%0d runs=%0d required 1/1", pc, run_cnt); end
    $display("mvi immediate out of range: error=%b", error);
  endtask

  task automatic test_timeout();
    int n = 0;
    do_reset();
    done_en = 1'b0;
    rom[0] = 9'b010_000_001;
    prog_len = 4'd2;
    push_words(0, 1);
    pulse_start();
    wait_runs(1, "timeout");
    // run is visible in the first WAIT_DONE cycle, so n counts cycles spent waiting
    while (n < TIMEOUT + 5) begin
      @(negedge clk); n++;
      if (error) break;
    end
    vectors += 2;
    if (n != TIMEOUT) begin miscompares++; $display("FAIL timeout_cycles: error after %0d cycles required %0d", n, TIMEOUT); end
    if ({halted, error, instr_cnt} !== {2'b11, 8'd0}) begin miscompares++; $display("FAIL timeout_state: h/e=%b cnt=%0d required 11/0", {halted, error}, instr_cnt); end
    $display("timeout: error after %0d cycles", n);
    done_en = 1'b1;
  endtask

  task automatic test_reset_irun();
    do_reset();
    rom[0] = 9'b001_011_000; rom[1] = 9'd7;
    prog_len = 4'd2;
    push_words(0, 1);
    pulse_start();
    wait_runs(1, "rstirun");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({busy, halted, error, pc, instr_cnt, bus.proc_din, bus.proc_run, bus.mem_rd_en, bus.mem_addr} !== 30'b0) begin
      miscompares++;
      $display("FAIL rstirun_outputs: busy=%b run=%b din=%h required all 0", busy, bus.proc_run, bus.proc_din);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if (run_cnt != 1 || busy !== 1'b0) begin miscompares++; $display("FAIL rstirun_abort: runs=%0d busy=%b required 1/0", run_cnt, busy); end
    run_cnt = 0;
    push_words(0, 2);
    pulse_start();
    wait_halt("rstirun");
    vectors += 2;
    if ({error, instr_cnt} !== {1'b0, 8'd1} || run_cnt != 2) begin miscompares++; $display("FAIL rstirun_restart: err=%b cnt=%0d runs=%0d required 0/1/2", error, instr_cnt, run_cnt); end
    if (regs[3] !== 9'd7) begin miscompares++; $display("FAIL rstirun_r3: %0d required 7", regs[3]); end
    $display("reset during IRUN then restart: cnt=%0d r3=%0d", instr_cnt, regs[3]);
  endtask

  task automatic test_zero_len_busy();
    do_reset();
    prog_len = 4'd0;
    pulse_start();
    vectors++;
    if ({halted, busy} !== 2'b10) begin miscompares++; $display("FAIL zero_halt: h/b=%b required 10", {halted, busy}); end
    repeat (3) @(negedge clk);
    vectors++;
    if (rd_cnt != 0) begin miscompares++; $display("FAIL zero_rd: %0d reads required 0", rd_cnt); end
    for (int i = 0; i < 3; i++) rom[i] = 9'b000_000_001;
    prog_len = 4'd3;
    push_words(0, 3);
    pulse_start();
    wait_runs(1, "busystart");
    pulse_start();
    wait_halt("busystart");
    vectors += 2;
    if ({instr_cnt, pc} !== {8'd3, 4'd3}) begin miscompares++; $display("FAIL busystart_cnt: cnt=%0d pc=%0d required 3/3", instr_cnt, pc); end
    if (run_cnt != 3 || exp_q.size() != 0) begin miscompares++; $display("FAIL busystart_runs: %0d runs required 3", run_cnt); end
    $display("zero length and busy start: cnt=%0d runs=%0d", instr_cnt, run_cnt);
  endtask

  initial begin
    test_reset();
    test_mvi_program();
    test_stop();
    test_illegal();
    test_halt_op();
    test_mvi_oob();
    test_timeout();
    test_reset_irun();
    test_zero_len_busy();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
